// File: rtl/pgm_gen.sv
// Multi-template packet generator: stores up to NUM_TPL template packets and
// replays a selected one pkt_num times (or until stopped) with a programmable
// inter-packet gap, optional sequence stamping and alf backpressure.
module pgm_gen #(
    parameter int unsigned DATA_W    = 134,
    parameter int unsigned TPL_DEPTH = 128,
    parameter int unsigned NUM_TPL   = 4,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned GAP_W     = 16,
    parameter int unsigned SEQ_EN    = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tpl_wr,
    input  logic [$clog2(NUM_TPL)-1:0] tpl_wsel,
    input  logic [DATA_W-1:0]          tpl_data,
    output logic                       tpl_werr,
    output logic [NUM_TPL-1:0]         tpl_valid,
    input  logic                       start,
    input  logic                       stop,
    input  logic [$clog2(NUM_TPL)-1:0] run_sel,
    input  logic [CNT_W-1:0]           pkt_num,
    input  logic [GAP_W-1:0]           gap_cycles,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_data_wr,
    output logic                       out_valid_wr,
    output logic                       out_valid,
    input  logic                       in_alf,
    output logic                       busy,
    output logic                       sent_start_flag,
    output logic                       sent_finish_flag,
    output logic [CNT_W-1:0]           sent_cnt
);

    localparam int unsigned AW  = $clog2(TPL_DEPTH);
    localparam int unsigned AW1 = AW + 1;
    localparam int unsigned SW  = $clog2(NUM_TPL);

    typedef enum logic [1:0] {StIdle, StArm, StSend, StGap} state_e;

    state_e state_q, state_d;

    // Per-slot template bookkeeping
    logic [NUM_TPL-1:0] valid_q;
    logic [NUM_TPL-1:0] open_q;      // head seen, tail not yet written
    logic [AW:0]        wr_addr_q [NUM_TPL];
    logic [AW-1:0]      last_idx_q [NUM_TPL];

    logic          wr_active, wr_head, wr_tail, wr_reject, mem_we;
    logic [AW-1:0] mem_widx;

    logic [DATA_W-1:0] mem [NUM_TPL*TPL_DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [AW-1:0]     rd_idx;

    logic [SW-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
    logic [AW-1:0]    idx_q, idx_d;  // index of the word currently on out_data
    logic             first_q, first_d;
    logic             stop_pend_q, stop_pend_d;
    logic             finish_q, finish_d;
    logic             werr_q, start_rej;

    logic send, at_tail, stop_any, last_pkt;

    assign send     = (state_q == StSend);
    assign at_tail  = send && (idx_q == last_idx_q[sel_q]);
    assign stop_any = stop | stop_pend_q;
    assign last_pkt = (num_q != '0) && ((sent_cnt_q + CNT_W'(1)) == num_q);

    // Template write decode: the slot being replayed is write-protected
    always_comb begin
        wr_active = (state_q != StIdle) && (tpl_wsel == sel_q);
        wr_head   = (tpl_data[DATA_W-1 -: 2] == 2'b01);
        wr_tail   = (tpl_data[DATA_W-1 -: 2] == 2'b10);
        mem_we    = 1'b0;
        mem_widx  = '0;
        wr_reject = 1'b0;
        if (tpl_wr) begin
            if (wr_active) begin
                wr_reject = 1'b1;
            end else if (wr_head) begin
                mem_we = 1'b1;
            end else if (!open_q[tpl_wsel] || (wr_addr_q[tpl_wsel] == AW1'(TPL_DEPTH))) begin
                wr_reject = 1'b1;
            end else begin
                mem_we   = 1'b1;
                mem_widx = wr_addr_q[tpl_wsel][AW-1:0];
            end
        end
    end

    // Slot state: write pointer, open/valid flags, stored length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            open_q  <= '0;
            for (int i = 0; i < int'(NUM_TPL); i++) begin
                wr_addr_q[i]  <= '0;
                last_idx_q[i] <= '0;
            end
        end else if (tpl_wr && !wr_active) begin
            if (wr_head) begin
                wr_addr_q[tpl_wsel] <= AW1'(1);
                open_q[tpl_wsel]    <= 1'b1;
                valid_q[tpl_wsel]   <= 1'b0;
            end else if (wr_reject) begin
                open_q[tpl_wsel]  <= 1'b0;
                valid_q[tpl_wsel] <= 1'b0;
            end else begin
                wr_addr_q[tpl_wsel] <= wr_addr_q[tpl_wsel] + AW1'(1);
                if (wr_tail) begin
                    last_idx_q[tpl_wsel] <= wr_addr_q[tpl_wsel][AW-1:0];
                    valid_q[tpl_wsel]    <= 1'b1;
                    open_q[tpl_wsel]     <= 1'b0;
                end
            end
        end
    end

    // Template RAM: one write port, one registered read port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[{tpl_wsel, mem_widx}] <= tpl_data;
        end
        rd_data_q <= mem[{sel_q, rd_idx}];
    end

    // Replay FSM next-state; the read address runs one word ahead of idx_q
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        num_d       = num_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        sent_cnt_d  = sent_cnt_q;
        idx_d       = idx_q;
        first_d     = first_q;
        stop_pend_d = stop_pend_q;
        finish_d    = 1'b0;
        start_rej   = 1'b0;
        rd_idx      = idx_q + AW'(1);
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (valid_q[run_sel]) begin
                        sel_d      = run_sel;
                        num_d      = pkt_num;
                        gap_d      = gap_cycles;
                        sent_cnt_d = '0;
                        first_d    = 1'b1;
                        state_d    = StArm;
                    end else begin
                        start_rej = 1'b1;
                    end
                end
            end
            StArm: begin
                if (stop_any) begin
                    state_d  = StIdle;
                    finish_d = 1'b1;
                end else if (!in_alf) begin
                    rd_idx  = '0;
                    idx_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                stop_pend_d = stop_any;
                if (at_tail) begin
                    sent_cnt_d = sent_cnt_q + CNT_W'(1);
                    first_d    = 1'b0;
                    if (last_pkt || stop_any) begin
                        state_d  = StIdle;
                        finish_d = 1'b1;
                    end else if (gap_q == '0) begin
                        state_d = StArm;
                    end else begin
                        state_d   = StGap;
                        gap_cnt_d = gap_q - GAP_W'(1);
                    end
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            StGap: begin
                if (stop_any) begin
                    state_d  = StIdle;
                    finish_d = 1'b1;
                end else if (gap_cnt_q == '0) begin
                    state_d = StArm;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StIdle) begin
            stop_pend_d = 1'b0;
        end
    end

    // Replay FSM state and run registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            num_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            sent_cnt_q  <= '0;
            idx_q       <= '0;
            first_q     <= 1'b0;
            stop_pend_q <= 1'b0;
            finish_q    <= 1'b0;
            werr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            num_q       <= num_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            sent_cnt_q  <= sent_cnt_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            stop_pend_q <= stop_pend_d;
            finish_q    <= finish_d;
            werr_q      <= wr_reject | start_rej;
        end
    end

    // Output bus: gated by SEND so reset blanks it immediately
    always_comb begin
        out_data = '0;
        if (send) begin
            out_data = rd_data_q;
            if ((SEQ_EN != 0) && (idx_q == '0)) begin
                out_data[CNT_W-1:0] = sent_cnt_q;
            end
        end
        out_data_wr      = send;
        out_valid_wr     = at_tail;
        out_valid        = at_tail;
        busy             = (state_q != StIdle);
        sent_start_flag  = send && (idx_q == '0) && first_q;
        sent_finish_flag = finish_q;
        sent_cnt         = sent_cnt_q;
        tpl_werr         = werr_q;
        tpl_valid        = valid_q;
    end

endmodule

// File: tb/tb_pgm_gen.sv
// Self-checking bench for pgm_gen: random templates replayed and compared
// against a packet-level reference model (word lists, seq stamps, timing).
module tb_pgm_gen;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tpl_wr = 1'b0;
    logic [1:0]   tpl_wsel = '0;
    logic [133:0] tpl_data = '0;
    logic         tpl_werr;
    logic [3:0]   tpl_valid;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [1:0]   run_sel = '0;
    logic [31:0]  pkt_num = '0;
    logic [15:0]  gap_cycles = '0;
    logic [133:0] out_data;
    logic         out_data_wr, out_valid_wr, out_valid;
    logic         in_alf = 1'b0;
    logic         busy, sent_start_flag, sent_finish_flag;
    logic [31:0]  sent_cnt;

    pgm_gen dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tpl_wr           (tpl_wr),
        .tpl_wsel         (tpl_wsel),
        .tpl_data         (tpl_data),
        .tpl_werr         (tpl_werr),
        .tpl_valid        (tpl_valid),
        .start            (start),
        .stop             (stop),
        .run_sel          (run_sel),
        .pkt_num          (pkt_num),
        .gap_cycles       (gap_cycles),
        .out_data         (out_data),
        .out_data_wr      (out_data_wr),
        .out_valid_wr     (out_valid_wr),
        .out_valid        (out_valid),
        .in_alf           (in_alf),
        .busy             (busy),
        .sent_start_flag  (sent_start_flag),
        .sent_finish_flag (sent_finish_flag),
        .sent_cnt         (sent_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output capture (sampled on the falling edge)
    logic [133:0] cap_data [$];
    bit           cap_vwr [$];
    bit           cap_v [$];
    int           cap_cyc [$];
    int head_cnt = 0, start_pulses = 0, fin_pulses = 0, werr_pulses = 0;

    always @(negedge clk) begin
        if (out_data_wr === 1'b1) begin
            cap_data.push_back(out_data);
            cap_vwr.push_back(out_valid_wr);
            cap_v.push_back(out_valid);
            cap_cyc.push_back(cyc);
            if (out_data[133:132] == 2'b01) head_cnt++;
        end
        if (sent_start_flag === 1'b1) start_pulses++;
        if (sent_finish_flag === 1'b1) fin_pulses++;
        if (tpl_werr === 1'b1) werr_pulses++;
    end

    // Reference model: stored templates
    logic [133:0] model_mem [4][128];
    int           model_len [4];
    logic [3:0]   model_valid = '0;

    int checks = 0;
    int errors = 0;
    int base_idx, fin_base, start_base, st_cyc;

    task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [133:0] rand_word(input logic [1:0] typ);
        logic [133:0] w;
        w[31:0]    = $urandom;
        w[63:32]   = $urandom;
        w[95:64]   = $urandom;
        w[127:96]  = $urandom;
        w[131:128] = 4'($urandom);
        w[133:132] = typ;
        return w;
    endfunction

    // Write a len-word packet (head, bodies, tail); model updated only if accepted
    task automatic write_tpl(input int slot, input int len, input bit accept);
        logic [133:0] w;
        logic [1:0]   typ;
        for (int i = 0; i < len; i++) begin
            typ      = (i == 0) ? 2'b01 : ((i == len - 1) ? 2'b10 : 2'b11);
            w        = rand_word(typ);
            tpl_wr   = 1'b1;
            tpl_wsel = 2'(slot);
            tpl_data = w;
            if (accept && i < 128) model_mem[slot][i] = w;
            tick();
        end
        tpl_wr = 1'b0;
        tick();
        if (accept) begin
            model_len[slot]   = len;
            model_valid[slot] = 1'b1;
        end
    endtask

    task automatic run_start(input int slot, input int num, input int gap);
        run_sel    = 2'(slot);
        pkt_num    = 32'(num);
        gap_cycles = 16'(gap);
        base_idx   = cap_data.size();
        fin_base   = fin_pulses;
        start_base = start_pulses;
        st_cyc     = cyc;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    // Compare a finished run against npk packets of the model template
    task automatic run_verify(input string tag, input int slot, input int npk, input int gap,
                              input int first_head);
        int len, got, p, i, k;
        logic [133:0] expw;
        wait_idle(tag);
        tick();
        tick();
        len = model_len[slot];
        got = cap_data.size() - base_idx;
        check({tag, "_nwords"}, got, npk * len);
        for (int j = 0; j < got && j < npk * len; j++) begin
            p = j / len;
            i = j % len;
            k = base_idx + j;
            expw = model_mem[slot][i];
            if (i == 0) expw[31:0] = 32'(p);
            check({tag, "_data"}, cap_data[k], expw);
            check({tag, "_tailflags"}, {cap_vwr[k], cap_v[k]}, (i == len - 1) ? 2'b11 : 2'b00);
            if (j == 0) check({tag, "_latency"}, cap_cyc[k], first_head);
            else if (i == 0) check({tag, "_gap"}, cap_cyc[k] - cap_cyc[k-1], gap + 2);
            else check({tag, "_beat"}, cap_cyc[k] - cap_cyc[k-1], 1);
        end
        check({tag, "_sent_cnt"}, sent_cnt, npk);
        check({tag, "_finish_pulses"}, fin_pulses - fin_base, 1);
        check({tag, "_start_pulses"}, start_pulses - start_base, 1);
    endtask

    initial begin
        int slot, len, num, gap, c, n, hb, wb, b;

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_out_wr", {out_data_wr, out_valid_wr, out_valid}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_tpl_valid", tpl_valid, 0);
        check("rst_sent_cnt", sent_cnt, 0);
        check("rst_flags", {tpl_werr, sent_start_flag, sent_finish_flag}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // T1: 4-word template, 3 packets, gap 2
        write_tpl(1, 4, 1'b1);
        check("t1_tpl_valid", tpl_valid, model_valid);
        run_start(1, 3, 2);
        run_verify("t1", 1, 3, 2, st_cyc + 2);

        // Random templates and run parameters
        for (int r = 0; r < 4; r++) begin
            slot = $urandom_range(0, 3);
            len  = $urandom_range(2, 12);
            num  = $urandom_range(1, 4);
            gap  = $urandom_range(0, 5);
            write_tpl(slot, len, 1'b1);
            check("rnd_tpl_valid", tpl_valid, model_valid);
            run_start(slot, num, gap);
            run_verify("rnd", slot, num, gap, st_cyc + 2);
        end

        // T2: alf holds ARM; alf mid-packet has no effect
        write_tpl(0, 6, 1'b1);
        in_alf = 1'b1;
        run_start(0, 1, 0);
        repeat (10) tick();
        check("t2_stall_words", cap_data.size() - base_idx, 0);
        check("t2_stall_busy", busy, 1);
        in_alf = 1'b0;
        c = cyc;
        tick();
        in_alf = 1'b1;
        run_verify("t2", 0, 1, 0, c + 1);
        in_alf = 1'b0;

        // T3: continuous run stopped during the second packet
        write_tpl(1, $urandom_range(3, 8), 1'b1);
        gap = $urandom_range(0, 3);
        hb  = head_cnt;
        run_start(1, 0, gap);
        n = 0;
        while (head_cnt - hb < 2 && n < 2000) begin
            tick();
            n++;
        end
        check("t3_second_head", head_cnt - hb, 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_verify("t3", 1, 2, gap, st_cyc + 2);

        // T4: 129-word template overflows; start on invalid slot ignored
        wb = werr_pulses;
        write_tpl(0, 129, 1'b0);
        model_valid[0] = 1'b0;
        check("t4_werr", werr_pulses - wb, 1);
        check("t4_tpl_valid", tpl_valid, model_valid);
        wb = werr_pulses;
        b  = cap_data.size();
        run_sel = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("t4_busy", busy, 0);
        check("t4_start_werr", werr_pulses - wb, 1);
        check("t4_no_words", cap_data.size() - b, 0);

        // T5: writes to the active slot rejected, other slot accepted
        write_tpl(2, 8, 1'b1);
        wb = werr_pulses;
        run_start(2, 3, 4);
        write_tpl(2, 5, 1'b0);
        write_tpl(3, 6, 1'b1);
        check("t5_werr", werr_pulses - wb, 5);
        check("t5_busy_during", busy, 1);
        run_verify("t5", 2, 3, 4, st_cyc + 2);
        check("t5_tpl_valid", tpl_valid, model_valid);
        run_start(3, 2, 1);
        run_verify("t5_slot3", 3, 2, 1, st_cyc + 2);

        // T6: asynchronous reset mid-packet
        run_start(3, 0, 1);
        n = 0;
        while (cap_data.size() - base_idx < 3 && n < 2000) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        #1;
        check("t6_out_wr", {out_data_wr, out_valid_wr, out_valid}, 0);
        check("t6_out_data", out_data, 0);
        check("t6_busy", busy, 0);
        check("t6_sent_cnt", sent_cnt, 0);
        check("t6_tpl_valid_rst", tpl_valid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        model_valid = '0;
        tick();
        check("t6_tpl_valid", tpl_valid, model_valid);
        wb = werr_pulses;
        run_sel = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("t6_start_ignored", busy, 0);
        check("t6_start_werr", werr_pulses - wb, 1);
        write_tpl(3, 5, 1'b1);
        run_start(3, 1, 0);
        run_verify("t6_after", 3, 1, 0, st_cyc + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
